// File: rtl/mandel_pixel_source_pkg.sv
// Shared definitions for the Mandelbrot pixel source: frame geometry,
// iteration encoding, palette/FSM types and the palette mapping function.
package mandel_pixel_source_pkg;

   localparam int unsigned H_ACT    = 640;
   localparam int unsigned V_ACT    = 480;
   localparam int unsigned FB_DEPTH = H_ACT * V_ACT;
   localparam int unsigned ADDR_W   = 20;
   localparam int unsigned ITER_W   = 8;
   localparam logic [ITER_W-1:0] MAX_ITER = 8'd255;

   typedef enum logic [1:0] {PAL_GREY, PAL_FIRE, PAL_ICE, PAL_BAND} pal_e;
   typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

   typedef struct packed {
      logic [9:0] r;
      logic [9:0] g;
      logic [9:0] b;
   } rgb_t;

   // 3*e computed with two spare bits so the saturation test never wraps
   function automatic logic [9:0] sat3(input logic [9:0] e);
      logic [11:0] t;
      t = {2'b00, e} + {1'b0, e, 1'b0};
      return (t > 12'd1023) ? 10'h3FF : t[9:0];
   endfunction

   // Iteration count -> 10-bit RGB; points inside the set are always black
   function automatic rgb_t pal_map(input logic [ITER_W-1:0] p, input pal_e sel);
      logic [9:0] e;
      rgb_t       c;
      e = {p, p[7:6]};
      c = '0;
      case (sel)
         PAL_GREY: c = '{r: e,       g: e, b: e};
         PAL_FIRE: c = '{r: sat3(e), g: e, b: {2'b00, e[9:2]}};
         PAL_ICE:  c = '{r: {2'b00, e[9:2]}, g: e, b: sat3(e)};
         PAL_BAND: c = '{r: {p[2:0], 7'h0}, g: {p[5:3], 7'h0}, b: {p[7:6], 8'h0}};
         default:  c = '0;
      endcase
      if (p == MAX_ITER) c = '0;
      return c;
   endfunction

endpackage

// File: rtl/mandel_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// A same-address read and write in one cycle returns the old word.
module mandel_frame_ram #(
   parameter int unsigned DEPTH = 307200,
   parameter int unsigned AW    = 19,
   parameter int unsigned DW    = 8
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];

   // Write and registered read; nonblocking update gives read-old-data
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/mandel_pixel_source.sv
// Frame buffer + palette stage feeding the VGA controller. Compute results
// arrive over a valid/ready port; reads return RGB two cycles after iAddress.
module mandel_pixel_source
   import mandel_pixel_source_pkg::*;
#(
   parameter int unsigned DEPTH = FB_DEPTH
) (
   input  logic              mCLK,
   input  logic              iRST_N,
   input  logic [ADDR_W-1:0] iAddress,
   input  logic              iWr_Valid,
   output logic              oWr_Ready,
   input  logic [ADDR_W-1:0] iWr_Addr,
   input  logic [ITER_W-1:0] iWr_Iter,
   input  logic              iClear,
   input  logic [1:0]        iPalette_Sel,
   output logic [9:0]        oRed,
   output logic [9:0]        oGreen,
   output logic [9:0]        oBlue,
   output logic              oFrame_Done,
   output logic              oClear_Busy
);

   localparam int unsigned       CW     = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] LIM    = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
   localparam logic [CW-1:0]     LAST_C = CW'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
   logic              rdy_q, done_q, oor_q;
   pal_e              pal_q;
   rgb_t              rgb_q;
   logic              ram_we;
   logic [CW-1:0]     ram_wa, ram_ra;
   logic [ITER_W-1:0] ram_wd, ram_q;
   logic              wr_acc, wr_in_rng, rd_in_rng;

   assign wr_acc    = iWr_Valid && rdy_q;
   assign wr_in_rng = iWr_Addr < LIM;
   assign rd_in_rng = iAddress < LIM;
   // Out-of-range reads are parked on word 0; oor_q forces black later
   assign ram_ra    = rd_in_rng ? iAddress[CW-1:0] : '0;

   // Next state and RAM write-port mux: engine writes in IDLE, sweep in CLEAR
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      ram_we    = 1'b0;
      ram_wa    = iWr_Addr[CW-1:0];
      ram_wd    = iWr_Iter;
      case (state_q)
         ST_IDLE: begin
            ram_we = wr_acc && wr_in_rng;
            if (iClear) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end
         end
         ST_CLEAR: begin
            ram_we = 1'b1;
            ram_wa = clr_cnt_q;
            ram_wd = MAX_ITER;
            if (clr_cnt_q == LAST_C) begin
               state_d   = ST_IDLE;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state; ready follows the next state so it is low through reset
   always_ff @(posedge mCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q   <= ST_IDLE;
         clr_cnt_q <= '0;
         rdy_q     <= 1'b0;
         done_q    <= 1'b0;
         pal_q     <= PAL_GREY;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         rdy_q     <= (state_d == ST_IDLE);
         done_q    <= wr_acc && (iWr_Addr == LAST_A);
         if (iAddress == '0) pal_q <= pal_e'(iPalette_Sel);
      end
   end

   mandel_frame_ram #(.DEPTH(DEPTH), .AW(CW), .DW(ITER_W)) u_ram (
      .clk_i   (mCLK),
      .we_i    (ram_we),
      .waddr_i (ram_wa),
      .wdata_i (ram_wd),
      .raddr_i (ram_ra),
      .rdata_o (ram_q)
   );

   // Read pipeline: stage 1 is the RAM register plus range flag, stage 2 RGB
   always_ff @(posedge mCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         oor_q <= 1'b1;
         rgb_q <= '0;
      end else begin
         oor_q <= !rd_in_rng;
         rgb_q <= oor_q ? '0 : pal_map(ram_q, pal_q);
      end
   end

   assign oWr_Ready   = rdy_q;
   assign oFrame_Done = done_q;
   assign oClear_Busy = (state_q == ST_CLEAR);
   assign oRed        = rgb_q.r;
   assign oGreen      = rgb_q.g;
   assign oBlue       = rgb_q.b;

endmodule

// File: tb/tb_mandel_pixel_source.sv
// Directed bench for mandel_pixel_source with a scoreboard on the RGB path.
// A reduced frame depth keeps the clear sweep short.
module tb_mandel_pixel_source;

   localparam int unsigned DEPTH = 2048;
   localparam logic [19:0] PARK  = 20'd7;

   logic        mCLK = 1'b0;
   logic        iRST_N;
   logic [19:0] iAddress;
   logic        iWr_Valid;
   logic        oWr_Ready;
   logic [19:0] iWr_Addr;
   logic [7:0]  iWr_Iter;
   logic        iClear;
   logic [1:0]  iPalette_Sel;
   logic [9:0]  oRed, oGreen, oBlue;
   logic        oFrame_Done;
   logic        oClear_Busy;

   typedef struct {
      int r;
      int g;
      int b;
   } exp_t;

   exp_t        sb_q[$];
   logic        mark = 1'b0;
   logic [1:0]  pipe = 2'b00;
   int          n_cmp = 0;
   int          n_bad = 0;

   mandel_pixel_source #(.DEPTH(DEPTH)) dut (
      .mCLK         (mCLK),
      .iRST_N       (iRST_N),
      .iAddress     (iAddress),
      .iWr_Valid    (iWr_Valid),
      .oWr_Ready    (oWr_Ready),
      .iWr_Addr     (iWr_Addr),
      .iWr_Iter     (iWr_Iter),
      .iClear       (iClear),
      .iPalette_Sel (iPalette_Sel),
      .oRed         (oRed),
      .oGreen       (oGreen),
      .oBlue        (oBlue),
      .oFrame_Done  (oFrame_Done),
      .oClear_Busy  (oClear_Busy)
   );

   always #5 mCLK = ~mCLK;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge mCLK);
      #1;
   endtask

   task automatic wr(input logic [19:0] a, input logic [7:0] it);
      iWr_Valid = 1'b1;
      iWr_Addr  = a;
      iWr_Iter  = it;
      tick();
      iWr_Valid = 1'b0;
   endtask

   task automatic rd(input logic [19:0] a, input int r, input int g, input int b);
      iAddress = a;
      mark     = 1'b1;
      sb_q.push_back('{r, g, b});
      tick();
      mark     = 1'b0;
      iAddress = PARK;
   endtask

   // Monitor: a marked address shows up after the second following edge
   initial begin
      exp_t e;
      forever begin
         @(posedge mCLK);
         pipe = {pipe[0], mark};
         @(negedge mCLK);
         if (pipe[1]) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++;
               $display("FAIL rgb: output with empty scoreboard");
            end else begin
               e = sb_q.pop_front();
               if (int'(oRed) != e.r || int'(oGreen) != e.g || int'(oBlue) != e.b) begin
                  n_bad++;
                  $display("FAIL rgb: got %0d,%0d,%0d want %0d,%0d,%0d",
                           oRed, oGreen, oBlue, e.r, e.g, e.b);
               end
            end
         end
      end
   end

   // Watchdog
   initial begin
      #300000;
      $display("FAIL timeout: simulation did not finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

   initial begin
      int cnt;
      iRST_N = 1'b0; iAddress = PARK; iWr_Valid = 1'b0; iWr_Addr = '0;
      iWr_Iter = '0; iClear = 1'b0; iPalette_Sel = 2'd0;
      repeat (3) tick();
      chk("rst_red", oRed, 0);
      chk("rst_green", oGreen, 0);
      chk("rst_blue", oBlue, 0);
      chk("rst_ready", oWr_Ready, 0);
      chk("rst_done", oFrame_Done, 0);
      chk("rst_busy", oClear_Busy, 0);
      iRST_N = 1'b1;
      tick();
      chk("ready_after_rst", oWr_Ready, 1);

      // iter 10 -> e = 40
      wr(20'd0, 8'd10);
      rd(20'd0, 40, 40, 40);

      // MAX_ITER is black in every palette; p=10 across palettes
      wr(20'd1234, 8'd255);
      iPalette_Sel = 2'd0; rd(20'd0, 40, 40, 40);   rd(20'd1234, 0, 0, 0);
      iPalette_Sel = 2'd1; rd(20'd0, 120, 40, 10);  rd(20'd1234, 0, 0, 0);
      iPalette_Sel = 2'd2; rd(20'd0, 10, 40, 120);  rd(20'd1234, 0, 0, 0);
      iPalette_Sel = 2'd3; rd(20'd0, 256, 128, 0);  rd(20'd1234, 0, 0, 0);
      // iter 200 -> e = 803; fire saturates red
      wr(20'd1235, 8'd200);
      iPalette_Sel = 2'd1; rd(20'd0, 120, 40, 10);  rd(20'd1235, 1023, 803, 200);
      iPalette_Sel = 2'd2; rd(20'd0, 10, 40, 120);  rd(20'd1235, 200, 803, 1023);
      iPalette_Sel = 2'd3; rd(20'd0, 256, 128, 0);  rd(20'd1235, 0, 128, 768);
      iPalette_Sel = 2'd0; rd(20'd0, 40, 40, 40);

      // Out-of-range reads and writes
      rd(20'd307200, 0, 0, 0);
      rd(20'hFFFFD, 0, 0, 0);
      rd(20'(DEPTH), 0, 0, 0);
      wr(20'(DEPTH), 8'd99);
      chk("oor_wr_ready", oWr_Ready, 1);
      chk("oor_wr_done", oFrame_Done, 0);
      rd(20'd0, 40, 40, 40);

      // Last word: frame-done pulse and read-old-data collision
      wr(20'(DEPTH - 1), 8'd50);
      chk("done_pulse1", oFrame_Done, 1);
      tick();
      chk("done_low1", oFrame_Done, 0);
      iWr_Valid = 1'b1; iWr_Addr = 20'(DEPTH - 1); iWr_Iter = 8'd200;
      iAddress = 20'(DEPTH - 1); mark = 1'b1;
      sb_q.push_back('{200, 200, 200});
      tick();
      iWr_Valid = 1'b0; mark = 1'b0; iAddress = PARK;
      chk("done_pulse2", oFrame_Done, 1);
      tick();
      chk("done_low2", oFrame_Done, 0);
      rd(20'(DEPTH - 1), 803, 803, 803);

      // Clear with a simultaneous write, then a held write during the sweep
      iClear = 1'b1; iWr_Valid = 1'b1; iWr_Addr = 20'd5; iWr_Iter = 8'd77;
      tick();
      iClear = 1'b0; iWr_Addr = 20'd9; iWr_Iter = 8'd33;
      chk("clr_busy", oClear_Busy, 1);
      cnt = 0;
      while (!oWr_Ready && cnt < DEPTH + 10) begin
         cnt++;
         if (cnt == DEPTH / 2) chk("clr_busy_mid", oClear_Busy, 1);
         tick();
      end
      chk("clr_ready_low_cycles", cnt, DEPTH);
      chk("clr_busy_end", oClear_Busy, 0);
      tick();
      iWr_Valid = 1'b0;
      rd(20'd0, 0, 0, 0);
      rd(20'(DEPTH / 2), 0, 0, 0);
      rd(20'(DEPTH - 1), 0, 0, 0);
      rd(20'd5, 0, 0, 0);
      rd(20'd9, 132, 132, 132);

      // Palette latched only while address 0 is presented
      wr(20'd0, 8'd10);
      wr(20'd3, 8'd10);
      iPalette_Sel = 2'd2;
      rd(20'd3, 40, 40, 40);
      rd(20'd0, 10, 40, 120);
      rd(20'd3, 10, 40, 120);
      repeat (3) tick();

      // Reset in the middle of a clear sweep
      iClear = 1'b1;
      tick();
      iClear = 1'b0;
      repeat (5) tick();
      chk("mid_clr_busy", oClear_Busy, 1);
      iRST_N = 1'b0;
      #1;
      chk("rst2_red", oRed, 0);
      chk("rst2_green", oGreen, 0);
      chk("rst2_blue", oBlue, 0);
      chk("rst2_ready", oWr_Ready, 0);
      chk("rst2_busy", oClear_Busy, 0);
      repeat (2) tick();
      iRST_N = 1'b1;
      tick();
      chk("rst2_ready_after", oWr_Ready, 1);
      repeat (3) tick();
      chk("rst2_idle_ready", oWr_Ready, 1);
      chk("rst2_idle_busy", oClear_Busy, 0);
      rd(20'd0, 0, 0, 0);

      repeat (4) tick();
      chk("sb_empty", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
